// File: rtl/ff_mode_pkg.sv
// Shared mode encoding for the command-driven D-storage register.
package ff_mode_pkg;

  typedef logic [1:0] ff_mode_t;

  localparam ff_mode_t MODE_SR = 2'b00;
  localparam ff_mode_t MODE_JK = 2'b01;
  localparam ff_mode_t MODE_D  = 2'b10;
  localparam ff_mode_t MODE_T  = 2'b11;

endpackage

// File: rtl/ff_mode_reg_if.sv
// Command/status bundle between control logic (master) and ff_mode_reg (slave).
interface ff_mode_reg_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
);
   import ff_mode_pkg::*;

   // No handshake: en qualifies mode/a/b for exactly the next rising edge;
   // clr_viol acts on that edge regardless of en.
   logic             en;
   ff_mode_t         mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             clr_viol;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qb;
   logic             viol;
   logic [CNT_W-1:0] viol_cnt;

   modport master (
      output en, mode, a, b, clr_viol,
      input  q, qb, viol, viol_cnt
   );

   modport slave (
      input  en, mode, a, b, clr_viol,
      output q, qb, viol, viol_cnt
   );

endinterface

// File: rtl/ff_mode_bit.sv
// One storage bit: converts an SR/JK/D/T command into the D input of a flop.
module ff_mode_bit
   import ff_mode_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     en,
   input  ff_mode_t mode,
   input  logic     a,
   input  logic     b,
   output logic     q,
   output logic     forbidden
);

   logic d_next;

   always_comb begin
      d_next = q;
      case (mode)
         MODE_SR: begin
            // 11 is forbidden and simply holds; the top level accounts for it
            if (a && !b)      d_next = 1'b1;
            else if (!a && b) d_next = 1'b0;
         end
         MODE_JK: begin
            case ({a, b})
               2'b10:   d_next = 1'b1;
               2'b01:   d_next = 1'b0;
               2'b11:   d_next = ~q;
               default: d_next = q;
            endcase
         end
         MODE_D:  d_next = a;
         MODE_T:  d_next = q ^ a;
         default: d_next = q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  q <= 1'b0;
      else if (en) q <= d_next;
   end

   assign forbidden = (mode == MODE_SR) && a && b;

endmodule

// File: rtl/ff_mode_reg.sv
// WIDTH-bit command-driven register with sticky forbidden-SR flag and saturating counter.
module ff_mode_reg
   import ff_mode_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input logic         clk,
   input logic         rst_n,
   ff_mode_reg_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [WIDTH-1:0] q_int;
   logic [WIDTH-1:0] forb;
   logic             viol_now;
   logic             viol_r;
   logic [CNT_W-1:0] cnt_r;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      ff_mode_bit u_bit (
         .clk       (clk),
         .rst_n     (rst_n),
         .en        (bus.en),
         .mode      (bus.mode),
         .a         (bus.a[i]),
         .b         (bus.b[i]),
         .q         (q_int[i]),
         .forbidden (forb[i])
      );
   end

   // One count per cycle no matter how many bits collide.
   assign viol_now = bus.en && (|forb);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         viol_r <= 1'b0;
         cnt_r  <= '0;
      end else if (viol_now) begin
         // A fresh violation beats a simultaneous clear.
         viol_r <= 1'b1;
         if (bus.clr_viol)          cnt_r <= CNT_ONE;
         else if (cnt_r != CNT_MAX) cnt_r <= cnt_r + CNT_ONE;
      end else if (bus.clr_viol) begin
         viol_r <= 1'b0;
         cnt_r  <= '0;
      end
   end

   assign bus.q        = q_int;
   assign bus.qb       = ~q_int;
   assign bus.viol     = viol_r;
   assign bus.viol_cnt = cnt_r;

endmodule

// File: tb/tb_ff_mode_reg.sv
// Bench for ff_mode_reg: directed scenarios plus randomized run against a vector-level model.
module tb_ff_mode_reg;
   import ff_mode_pkg::*;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   // reference model state
   logic [7:0] m_q;
   logic       m_viol;
   int         m_cnt8;
   int         m_cnt2;

   ff_mode_reg_if #(.WIDTH(8), .CNT_W(8)) bus ();
   ff_mode_reg_if #(.WIDTH(8), .CNT_W(2)) bus2 ();

   ff_mode_reg #(.WIDTH(8), .CNT_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   ff_mode_reg #(.WIDTH(8), .CNT_W(2)) dut_sat (.clk(clk), .rst_n(rst_n), .bus(bus2));

   assign bus2.en       = bus.en;
   assign bus2.mode     = bus.mode;
   assign bus2.a        = bus.a;
   assign bus2.b        = bus.b;
   assign bus2.clr_viol = bus.clr_viol;

   // clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // vector-level characteristic equations
   function automatic logic [7:0] model_next(input logic [7:0] q, input ff_mode_t m,
                                             input logic [7:0] a, input logic [7:0] b);
      case (m)
         MODE_SR: return (q | (a & ~b)) & ~(b & ~a);
         MODE_JK: return (a & ~q) | (~b & q);
         MODE_D:  return a;
         default: return q ^ a;
      endcase
   endfunction

   task automatic model_reset();
      m_q = 8'h00; m_viol = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
   endtask

   // driver: present one command, advance the model, sample 1ns after the edge
   task automatic cyc(input logic e, input ff_mode_t m, input logic [7:0] av,
                      input logic [7:0] bv, input logic c);
      bus.en = e; bus.mode = m; bus.a = av; bus.b = bv; bus.clr_viol = c;
      if (e && m == MODE_SR && (av & bv) != 8'h00) begin
         m_viol = 1'b1;
         m_cnt8 = c ? 1 : ((m_cnt8 < 255) ? m_cnt8 + 1 : 255);
         m_cnt2 = c ? 1 : ((m_cnt2 < 3) ? m_cnt2 + 1 : 3);
      end else if (c) begin
         m_viol = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
      end
      if (e) m_q = model_next(m_q, m, av, bv);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.en = 1'b1; bus.mode = ff_mode_t'($urandom_range(0, 3));
      bus.a = 8'($urandom); bus.b = 8'($urandom); bus.clr_viol = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      checks++; if (bus.q !== 8'h00) begin errors++; $display("FAIL reset_q got=%h exp=00", bus.q); end
      checks++; if (bus.qb !== 8'hFF) begin errors++; $display("FAIL reset_qb got=%h exp=FF", bus.qb); end
      checks++; if (bus.viol !== 1'b0) begin errors++; $display("FAIL reset_viol got=%b exp=0", bus.viol); end
      checks++; if (bus.viol_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", bus.viol_cnt); end
      checks++; if (bus2.viol_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt2 got=%0d exp=0", bus2.viol_cnt); end
      bus.en = 1'b0;
      rst_n = 1'b1;
      cyc(1'b1, MODE_D, 8'hA5, 8'h00, 1'b0);
      checks++; if (bus.q !== 8'hA5) begin errors++; $display("FAIL load_a5 got=%h exp=A5", bus.q); end
      // asynchronous assert mid-cycle, before the next edge
      bus.a = 8'h3C;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      checks++; if (bus.q !== 8'h00) begin errors++; $display("FAIL async_rst_q got=%h exp=00", bus.q); end
      checks++; if (bus.qb !== 8'hFF) begin errors++; $display("FAIL async_rst_qb got=%h exp=FF", bus.qb); end
      bus.en = 1'b0;
      #1 rst_n = 1'b1;
   endtask

   task automatic test_sr();
      cyc(1'b1, MODE_SR, 8'h0F, 8'h00, 1'b0);
      checks++; if (bus.q !== 8'h0F) begin errors++; $display("FAIL sr_set got=%h exp=0F", bus.q); end
      cyc(1'b1, MODE_SR, 8'h00, 8'h03, 1'b0);
      checks++; if (bus.q !== 8'h0C) begin errors++; $display("FAIL sr_reset got=%h exp=0C", bus.q); end
      checks++; if (bus.qb !== 8'hF3) begin errors++; $display("FAIL sr_qb got=%h exp=F3", bus.qb); end
      cyc(1'b0, MODE_SR, 8'hFF, 8'h00, 1'b0);
      checks++; if (bus.q !== 8'h0C) begin errors++; $display("FAIL sr_en_low got=%h exp=0C", bus.q); end
      cyc(1'b0, MODE_SR, 8'hFF, 8'hFF, 1'b0);
      checks++; if (bus.viol !== 1'b0) begin errors++; $display("FAIL sr_en_low_viol got=%b exp=0", bus.viol); end
   endtask

   task automatic test_forbidden();
      cyc(1'b1, MODE_SR, 8'h81, 8'h01, 1'b0);
      checks++; if (bus.q !== 8'h8C) begin errors++; $display("FAIL forb_q got=%h exp=8C", bus.q); end
      checks++; if (bus.viol !== 1'b1) begin errors++; $display("FAIL forb_viol got=%b exp=1", bus.viol); end
      checks++; if (bus.viol_cnt !== 8'd1) begin errors++; $display("FAIL forb_cnt1 got=%0d exp=1", bus.viol_cnt); end
      for (int i = 0; i < 3; i++) cyc(1'b1, MODE_SR, 8'h03, 8'h03, 1'b0);
      checks++; if (bus.viol_cnt !== 8'd4) begin errors++; $display("FAIL forb_cnt4 got=%0d exp=4", bus.viol_cnt); end
      checks++; if (bus.q !== 8'h8C) begin errors++; $display("FAIL forb_hold got=%h exp=8C", bus.q); end
   endtask

   task automatic test_jk_t_d();
      cyc(1'b1, MODE_D, 8'h0C, 8'h00, 1'b1);
      checks++; if (bus.q !== 8'h0C || bus.viol !== 1'b0) begin
         errors++; $display("FAIL jk_setup q=%h viol=%b exp=0C/0", bus.q, bus.viol); end
      cyc(1'b1, MODE_JK, 8'hFF, 8'hFF, 1'b0);
      checks++; if (bus.q !== 8'hF3) begin errors++; $display("FAIL jk_toggle got=%h exp=F3", bus.q); end
      checks++; if (bus.viol !== 1'b0) begin errors++; $display("FAIL jk_no_viol got=%b exp=0", bus.viol); end
      cyc(1'b1, MODE_T, 8'h01, 8'hFF, 1'b0);
      checks++; if (bus.q !== 8'hF2) begin errors++; $display("FAIL t_toggle got=%h exp=F2", bus.q); end
      cyc(1'b1, MODE_D, 8'h5A, 8'hFF, 1'b0);
      checks++; if (bus.q !== 8'h5A) begin errors++; $display("FAIL d_load got=%h exp=5A", bus.q); end
      checks++; if (bus.qb !== 8'hA5) begin errors++; $display("FAIL d_qb got=%h exp=A5", bus.qb); end
   endtask

   task automatic test_saturation();
      rst_n = 1'b0;
      #1;
      model_reset();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) cyc(1'b1, MODE_SR, 8'hFF, 8'hFF, 1'b0);
      checks++; if (bus2.viol_cnt !== 2'd3) begin errors++; $display("FAIL sat_cnt2 got=%0d exp=3", bus2.viol_cnt); end
      checks++; if (bus.viol_cnt !== 8'd5) begin errors++; $display("FAIL sat_cnt8 got=%0d exp=5", bus.viol_cnt); end
      cyc(1'b0, MODE_SR, 8'hFF, 8'hFF, 1'b1);
      checks++; if (bus2.viol !== 1'b0 || bus2.viol_cnt !== 2'd0) begin
         errors++; $display("FAIL clr_alone viol=%b cnt=%0d exp=0/0", bus2.viol, bus2.viol_cnt); end
      for (int i = 0; i < 2; i++) cyc(1'b1, MODE_SR, 8'h10, 8'h10, 1'b0);
      cyc(1'b1, MODE_SR, 8'h01, 8'h01, 1'b1);
      checks++; if (bus2.viol !== 1'b1 || bus2.viol_cnt !== 2'd1) begin
         errors++; $display("FAIL clr_with_viol viol=%b cnt=%0d exp=1/1", bus2.viol, bus2.viol_cnt); end
      checks++; if (bus.viol_cnt !== 8'd1) begin errors++; $display("FAIL clr_with_viol8 got=%0d exp=1", bus.viol_cnt); end
   endtask

   task automatic test_random();
      logic     e;
      ff_mode_t m;
      logic     c;
      for (int n = 0; n < 1000; n++) begin
         e = ($urandom_range(0, 7) != 0);
         m = ff_mode_t'($urandom_range(0, 3));
         c = ($urandom_range(0, 15) == 0);
         cyc(e, m, 8'($urandom), 8'($urandom), c);
         checks++; if (bus.q !== m_q) begin errors++; $display("FAIL rnd_q n=%0d got=%h exp=%h", n, bus.q, m_q); end
         checks++; if (bus.qb !== ~m_q || bus2.qb !== ~bus2.q) begin
            errors++; $display("FAIL rnd_qb n=%0d got=%h exp=%h", n, bus.qb, ~m_q); end
         checks++; if (bus.viol !== m_viol) begin errors++; $display("FAIL rnd_viol n=%0d got=%b exp=%b", n, bus.viol, m_viol); end
         checks++; if (bus.viol_cnt !== 8'(m_cnt8)) begin
            errors++; $display("FAIL rnd_cnt8 n=%0d got=%0d exp=%0d", n, bus.viol_cnt, m_cnt8); end
         checks++; if (bus2.viol_cnt !== 2'(m_cnt2) || bus2.q !== m_q) begin
            errors++; $display("FAIL rnd_sat n=%0d cnt=%0d exp=%0d", n, bus2.viol_cnt, m_cnt2); end
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n = 1'b0;
      bus.en = 1'b0; bus.mode = MODE_SR; bus.a = 8'h00; bus.b = 8'h00; bus.clr_viol = 1'b0;
      model_reset();
      test_reset();
      test_sr();
      test_forbidden();
      test_jk_t_d();
      test_saturation();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
